// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer scheduler: tone divisors, note codes,
// song base addresses, requester indices and ROM word layout.
package buzzer_pkg;

  localparam int REQ_CLICK = 0;
  localparam int REQ_CHIME = 1;
  localparam int REQ_ALARM = 2;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_M1   = 4'd8;
  localparam logic [3:0] NOTE_M3   = 4'd10;
  localparam logic [3:0] NOTE_M5   = 4'd12;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam logic [5:0] BASE_CLICK = 6'd0;
  localparam logic [5:0] BASE_CHIME = 6'd8;
  localparam logic [5:0] BASE_ALARM = 6'd16;

  localparam logic [17:0] L_1 = 18'd127552;
  localparam logic [17:0] L_2 = 18'd113636;
  localparam logic [17:0] L_3 = 18'd101236;
  localparam logic [17:0] L_4 = 18'd95548;
  localparam logic [17:0] L_5 = 18'd85136;
  localparam logic [17:0] L_6 = 18'd75838;
  localparam logic [17:0] L_7 = 18'd67567;
  localparam logic [17:0] M_1 = 18'd63776;
  localparam logic [17:0] M_2 = 18'd56818;
  localparam logic [17:0] M_3 = 18'd50607;
  localparam logic [17:0] M_4 = 18'd47778;
  localparam logic [17:0] M_5 = 18'd42553;
  localparam logic [17:0] M_6 = 18'd37936;
  localparam logic [17:0] M_7 = 18'd33783;

  typedef struct packed {
    logic [3:0] code;
    logic [1:0] rsvd;
    logic [1:0] beats_m1;
  } rom_word_t;

  function automatic logic [7:0] make_word(input logic [3:0] code, input logic [1:0] beats_m1);
    return {code, 2'b00, beats_m1};
  endfunction

  // Rest and END both map to silence.
  function automatic logic [17:0] note_div(input logic [3:0] code);
    logic [17:0] div;
    case (code)
      NOTE_REST: div = 18'd0;
      4'd1:      div = L_1;
      4'd2:      div = L_2;
      4'd3:      div = L_3;
      4'd4:      div = L_4;
      4'd5:      div = L_5;
      4'd6:      div = L_6;
      4'd7:      div = L_7;
      4'd8:      div = M_1;
      4'd9:      div = M_2;
      4'd10:     div = M_3;
      4'd11:     div = M_4;
      4'd12:     div = M_5;
      4'd13:     div = M_6;
      4'd14:     div = M_7;
      default:   div = 18'd0;
    endcase
    return div;
  endfunction

  function automatic logic [5:0] song_base(input logic [2:0] grant_oh);
    logic [5:0] base;
    if (grant_oh[REQ_ALARM])      base = BASE_ALARM;
    else if (grant_oh[REQ_CHIME]) base = BASE_CHIME;
    else                          base = BASE_CLICK;
    return base;
  endfunction

endpackage

// File: rtl/buzzer_scheduler_if.sv
// Melody ROM read port: the scheduler drives the address, the ROM returns
// the registered word one edge later.
interface buzzer_scheduler_if;
  logic [5:0] addr;
  logic [7:0] data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);
endinterface

// File: rtl/melody_rom.sv
// 64x8 synchronous-read song table. Unused locations read as END so a
// runaway address always terminates the melody.
module melody_rom
  import buzzer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  buzzer_scheduler_if.slave   bus
);

  logic [7:0] data_d;
  logic [7:0] data_q;

  always_comb begin
    data_d = make_word(NOTE_END, 2'd0);
    case (bus.addr)
      6'd0:    data_d = make_word(NOTE_M5, 2'd0);
      6'd1:    data_d = make_word(NOTE_END, 2'd0);
      6'd8:    data_d = make_word(NOTE_M1, 2'd0);
      6'd9:    data_d = make_word(NOTE_M3, 2'd0);
      6'd10:   data_d = make_word(NOTE_M5, 2'd1);
      6'd11:   data_d = make_word(NOTE_END, 2'd0);
      6'd16:   data_d = make_word(NOTE_M5, 2'd1);
      6'd17:   data_d = make_word(NOTE_REST, 2'd0);
      6'd18:   data_d = make_word(NOTE_M5, 2'd0);
      6'd19:   data_d = make_word(NOTE_M1, 2'd0);
      6'd20:   data_d = make_word(NOTE_END, 2'd0);
      default: data_d = make_word(NOTE_END, 2'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign bus.data = data_q;

endmodule

// File: rtl/buzzer_scheduler.sv
// Arbitrates the buzzer between click, chime and alarm and plays the
// winner's melody note by note, driving the tone generator divisor.
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int BEAT_CYCLES  = 25000000,
  parameter int GAP_CYCLES   = 2500000,
  parameter int ALARM_REPEAT = 3,
  parameter int DIV_W        = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic             stop,
  output logic [2:0]       grant,
  output logic [DIV_W-1:0] tone_div,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [27:0] BEAT_LEN = 28'(BEAT_CYCLES);
  localparam logic [27:0] GAP_LEN  = (GAP_CYCLES > 0) ? 28'(GAP_CYCLES - 1) : 28'd0;
  localparam logic [7:0]  REP_LAST = (ALARM_REPEAT > 0) ? 8'(ALARM_REPEAT - 1) : 8'd0;

  logic [2:0]       state_d, state_q;
  logic [2:0]       grant_d, grant_q;
  logic [2:0]       pending_d, pending_q;
  logic [5:0]       addr_d, addr_q;
  logic [27:0]      cnt_d, cnt_q;
  logic [DIV_W-1:0] tone_d, tone_q;
  logic [7:0]       rep_d, rep_q;

  logic [2:0] top_pending;
  logic [2:0] take;
  logic       preempt;
  logic       boundary;
  rom_word_t  word;
  logic       rsvd_unused;

  buzzer_scheduler_if rom_if ();

  melody_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rom_if)
  );

  // The ROM samples the next address so its output is valid in FETCH.
  assign rom_if.addr = addr_d;
  assign word        = rom_word_t'(rom_if.data);
  assign rsvd_unused = ^word.rsvd;

  always_comb begin
    top_pending = 3'b000;
    if (pending_q[REQ_ALARM])      top_pending[REQ_ALARM] = 1'b1;
    else if (pending_q[REQ_CHIME]) top_pending[REQ_CHIME] = 1'b1;
    else if (pending_q[REQ_CLICK]) top_pending[REQ_CLICK] = 1'b1;
  end

  assign preempt = (grant_q[REQ_CLICK] & (pending_q[REQ_CHIME] | pending_q[REQ_ALARM]))
                 | (grant_q[REQ_CHIME] & pending_q[REQ_ALARM]);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tone_d   = tone_q;
    rep_d    = rep_q;
    take     = 3'b000;
    boundary = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          take    = top_pending;
          grant_d = top_pending;
          addr_d  = song_base(top_pending);
          rep_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (word.code == NOTE_END) begin
          if (grant_q[REQ_ALARM] && (rep_q < REP_LAST)) begin
            rep_d  = rep_q + 8'd1;
            addr_d = song_base(grant_q);
          end else begin
            rep_d   = '0;
            grant_d = '0;
            tone_d  = '0;
            state_d = S_DONE;
          end
        end else begin
          tone_d  = DIV_W'(note_div(word.code));
          cnt_d   = (28'(word.beats_m1) + 28'd1) * BEAT_LEN - 28'd1;
          addr_d  = addr_q + 6'd1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cnt_q != 28'd0) begin
          cnt_d = cnt_q - 28'd1;
        end else if (GAP_CYCLES > 0) begin
          tone_d  = '0;
          cnt_d   = GAP_LEN;
          state_d = S_GAP;
        end else begin
          boundary = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != 28'd0) cnt_d = cnt_q - 28'd1;
        else                boundary = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Note boundary: a higher-priority pending song discards the current one.
    if (boundary) begin
      state_d = S_FETCH;
      if (preempt) begin
        take    = top_pending;
        grant_d = top_pending;
        addr_d  = song_base(top_pending);
        rep_d   = '0;
        tone_d  = '0;
      end
    end

    pending_d = (pending_q | (req & ~grant_q)) & ~take;

    if (stop) begin
      state_d   = S_IDLE;
      grant_d   = '0;
      tone_d    = '0;
      rep_d     = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tone_q    <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tone_q    <= tone_d;
      rep_q     <= rep_d;
    end
  end

  assign grant    = grant_q;
  assign tone_div = tone_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with a short beat (10 cycles) and a
// 2-cycle gap: run-length vector table plus multi-cycle corner sequences.
module tb_buzzer_scheduler;

  localparam logic [17:0] T_M1 = 18'd63776;
  localparam logic [17:0] T_M3 = 18'd50607;
  localparam logic [17:0] T_M5 = 18'd42553;
  localparam int NV = 21;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic        stop;
  logic [2:0]  grant;
  logic [17:0] tone_div;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];

  typedef struct {
    logic [2:0]  req;
    logic        stop;
    int          n;
    logic [2:0]  grant;
    logic [17:0] tone;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs [NV];

  buzzer_scheduler #(
    .BEAT_CYCLES  (10),
    .GAP_CYCLES   (2),
    .ALARM_REPEAT (3),
    .DIV_W        (18)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .stop     (stop),
    .grant    (grant),
    .tone_div (tone_div),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic [17:0] t,
                            input logic b, input logic d);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".tone_div"}, 32'(tone_div), 32'(t));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic [2:0] r, input logic s);
    @(negedge clk);
    req  = r;
    stop = s;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [17:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  initial begin
    logic [17:0] exp_tone;

    vecs[0]  = '{3'b001, 1'b0, 1,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 1'b0, 1,  3'b001, 18'd0, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 1'b0, 10, 3'b001, T_M5,  1'b1, 1'b0};
    vecs[3]  = '{3'b000, 1'b0, 3,  3'b001, 18'd0, 1'b1, 1'b0};
    vecs[4]  = '{3'b000, 1'b0, 1,  3'b000, 18'd0, 1'b1, 1'b1};
    vecs[5]  = '{3'b000, 1'b0, 3,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 1'b0, 1,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 1'b0, 1,  3'b010, 18'd0, 1'b1, 1'b0};
    vecs[8]  = '{3'b000, 1'b0, 10, 3'b010, T_M1,  1'b1, 1'b0};
    vecs[9]  = '{3'b000, 1'b0, 3,  3'b010, 18'd0, 1'b1, 1'b0};
    vecs[10] = '{3'b000, 1'b0, 10, 3'b010, T_M3,  1'b1, 1'b0};
    vecs[11] = '{3'b000, 1'b0, 3,  3'b010, 18'd0, 1'b1, 1'b0};
    vecs[12] = '{3'b000, 1'b0, 20, 3'b010, T_M5,  1'b1, 1'b0};
    vecs[13] = '{3'b000, 1'b0, 3,  3'b010, 18'd0, 1'b1, 1'b0};
    vecs[14] = '{3'b000, 1'b0, 1,  3'b000, 18'd0, 1'b1, 1'b1};
    vecs[15] = '{3'b000, 1'b0, 2,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[16] = '{3'b100, 1'b0, 1,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[17] = '{3'b000, 1'b0, 1,  3'b100, 18'd0, 1'b1, 1'b0};
    vecs[18] = '{3'b000, 1'b0, 5,  3'b100, T_M5,  1'b1, 1'b0};
    vecs[19] = '{3'b001, 1'b1, 1,  3'b000, 18'd0, 1'b0, 1'b0};
    vecs[20] = '{3'b000, 1'b0, 6,  3'b000, 18'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 3'b000;
    stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 3'b000, 18'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Click, chime, and stop-with-simultaneous-request
    for (int v = 0; v < NV; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        step(vecs[v].req, vecs[v].stop);
        expect_out($sformatf("vec%0d.c%0d", v, c), vecs[v].grant, vecs[v].tone,
                   vecs[v].busy, vecs[v].done);
      end
    end

    // Alarm melody three times back to back, then one done pulse
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      push(18'd0, 1); push(T_M5, 20); push(18'd0, 3);
      push(18'd0, 10); push(18'd0, 3);
      push(T_M5, 10);  push(18'd0, 3);
      push(T_M1, 10);  push(18'd0, 3);
    end
    step(3'b100, 1'b0);
    expect_out("alarm.req", 3'b000, 18'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      exp_tone = exp_q.pop_front();
      step(3'b000, 1'b0);
      expect_out($sformatf("alarm.left%0d", exp_q.size()), 3'b100, exp_tone, 1'b1, 1'b0);
    end
    step(3'b000, 1'b0);
    expect_out("alarm.done", 3'b000, 18'd0, 1'b1, 1'b1);
    step(3'b000, 1'b0);
    expect_out("alarm.idle", 3'b000, 18'd0, 1'b0, 1'b0);

    // Alarm requested mid-note of the chime takes over after the gap
    step(3'b010, 1'b0);
    expect_out("pre.req", 3'b000, 18'd0, 1'b0, 1'b0);
    step(3'b000, 1'b0);
    expect_out("pre.fetch", 3'b010, 18'd0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("pre.note_a%0d", c), 3'b010, T_M1, 1'b1, 1'b0);
    end
    step(3'b100, 1'b0);
    expect_out("pre.alarm_req", 3'b010, T_M1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("pre.note_b%0d", c), 3'b010, T_M1, 1'b1, 1'b0);
    end
    for (int c = 0; c < 2; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("pre.gap%0d", c), 3'b010, 18'd0, 1'b1, 1'b0);
    end
    step(3'b000, 1'b0);
    expect_out("pre.switch", 3'b100, 18'd0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("pre.alarm%0d", c), 3'b100, T_M5, 1'b1, 1'b0);
    end
    step(3'b000, 1'b1);
    expect_out("pre.stop", 3'b000, 18'd0, 1'b0, 1'b0);
    step(3'b000, 1'b0);
    expect_out("pre.idle", 3'b000, 18'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a note
    step(3'b001, 1'b0);
    expect_out("rst.req", 3'b000, 18'd0, 1'b0, 1'b0);
    step(3'b000, 1'b0);
    expect_out("rst.fetch", 3'b001, 18'd0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("rst.play%0d", c), 3'b001, T_M5, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 3'b000, 18'd0, 1'b0, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(3'b000, 1'b0);
      expect_out($sformatf("rst.idle%0d", c), 3'b000, 18'd0, 1'b0, 1'b0);
    end
    step(3'b001, 1'b0);
    expect_out("rst.new_req", 3'b000, 18'd0, 1'b0, 1'b0);
    step(3'b000, 1'b0);
    expect_out("rst.new_grant", 3'b001, 18'd0, 1'b1, 1'b0);
    step(3'b000, 1'b0);
    expect_out("rst.new_tone", 3'b001, T_M5, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
